// File: rtl/uart_frame_ctrl_if.sv
// Bundle between the UART frame sequencer and its neighbours: the byte
// receiver handshake, the frame buffer write port and the consumer side.
// master: the sequencer; slave: receiver/buffer/consumer environment.
interface uart_frame_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_available;
  logic              rx_clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic [7:0]        frame_len;
  logic              frame_ack;
  logic              frame_err;
  logic [1:0]        err_code;
  logic [7:0]        drop_cnt;
  logic              busy;

  modport master (
    input  rx_data, rx_available, frame_ack,
    output rx_clear, wr_en, wr_addr, wr_data, frame_done, frame_len,
           frame_err, err_code, drop_cnt, busy
  );

  modport slave (
    output rx_data, rx_available, frame_ack,
    input  rx_clear, wr_en, wr_addr, wr_data, frame_done, frame_len,
           frame_err, err_code, drop_cnt, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame sequencer: drains the byte receiver, parses SYNC/LEN/payload/
// checksum frames, writes payload to the frame buffer and reports done/error.
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables the inter-byte
// timeout (err_code 3); without it a partial frame waits indefinitely.
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 64,
  parameter int         ADDR_W         = 6,
  parameter int         TIMEOUT_CYCLES = 27000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAY, S_CHK, S_HOLD} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        idx_q, idx_d;
  logic              rx_clear_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        drop_q, drop_d;
  logic              busy_q;
  logic              consume;

  // While rx_clear is high the receiver has not yet dropped its flag.
  assign consume = bus.rx_available && !rx_clear_q;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    frame_len_d = frame_len_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    drop_d      = drop_q;

    unique case (state_q)
      S_SYNC: begin
        if (consume && bus.rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (consume) begin
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
            state_d    = S_SYNC;
          end else begin
            len_d   = bus.rx_data;
            sum_d   = bus.rx_data;
            idx_d   = 8'd0;
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (consume) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = bus.rx_data;
          sum_d     = sum_q + bus.rx_data;
          idx_d     = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (consume) begin
          if (bus.rx_data == sum_q) begin
            done_d      = 1'b1;
            frame_len_d = len_q;
            state_d     = S_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_SYNC;
          end
        end
      end
      S_HOLD: begin
        // An ack releases the buffer; a byte arriving on that edge is not counted.
        if (bus.frame_ack) begin
          drop_d  = 8'd0;
          state_d = S_SYNC;
        end else if (consume && drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = S_SYNC;
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    // A consume on the timeout edge wins: the counter restarts instead.
    tmo_d = '0;
    if ((state_q == S_LEN || state_q == S_PAY || state_q == S_CHK) && !consume) begin
      if (tmo_hit) begin
        err_d      = 1'b1;
        err_code_d = 2'd3;
        state_d    = S_SYNC;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      rx_clear_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      frame_len_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      drop_q      <= '0;
      busy_q      <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      rx_clear_q  <= consume;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      frame_len_q <= frame_len_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
      busy_q      <= (state_d != S_SYNC);
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.rx_clear   = rx_clear_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = done_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: frame parsing, errors, hold/drop,
// timeout (or its absence) and mid-frame reset.
module tb_uart_frame_ctrl;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_ctrl #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(64), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int wr_addr_log [256];
  int wr_data_log [256];
  int wr_cyc_log  [256];

  logic       done_at_clr;
  int         clr_cyc;
  logic [7:0] seq [$];

  // Cycle counter advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the inactive edge.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_addr_log[wr_cnt % 256] <= int'(bus.wr_addr);
      wr_data_log[wr_cnt % 256] <= int'(bus.wr_data);
      wr_cyc_log[wr_cnt % 256]  <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.frame_done) done_cnt <= done_cnt + 1;
    if (bus.frame_err)  err_cnt  <= err_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic present(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_available = 1'b1;
  endtask

  // Wait for the clear pulse, then drop the flag one cycle later like the receiver.
  task automatic finish_byte();
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.rx_clear) seen = 1'b1;
    end
    if (!seen) check("rx_clear_wait", 32'd0, 32'd1);
    done_at_clr = bus.frame_done;
    clr_cyc     = cyc;
    @(negedge clk);
    bus.rx_available = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    present(b);
    finish_byte();
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic ack_pulse();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_out_zero(input string tag);
    check({tag, "_pulses"}, {bus.rx_clear, bus.wr_en, bus.frame_done, bus.frame_err, bus.busy}, 0);
    check({tag, "_wr_addr"},   bus.wr_addr,   0);
    check({tag, "_wr_data"},   bus.wr_data,   0);
    check({tag, "_frame_len"}, bus.frame_len, 0);
    check({tag, "_err_code"},  bus.err_code,  0);
    check({tag, "_drop_cnt"},  bus.drop_cnt,  0);
  endtask

  initial begin
    int wb, db, eb, ecyc;
    bit found;
    bus.rx_data      = 8'h00;
    bus.rx_available = 1'b0;
    bus.frame_ack    = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check_out_zero("rst");
    rst_n = 1'b1;
    idle(2);

    // Good frame preceded by a stray byte.
    wb = wr_cnt; db = done_cnt; eb = err_cnt;
    seq = '{8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq();
    check("t1_done_latency", done_at_clr, 1);
    idle(2);
    check("t1_wr_count", wr_cnt - wb, 3);
    check("t1_addr0", wr_addr_log[wb], 0);
    check("t1_data0", wr_data_log[wb], 32'h11);
    check("t1_addr1", wr_addr_log[wb+1], 1);
    check("t1_data1", wr_data_log[wb+1], 32'h22);
    check("t1_addr2", wr_addr_log[wb+2], 2);
    check("t1_data2", wr_data_log[wb+2], 32'h33);
    check("t1_wr_gap", wr_cyc_log[wb+1] - wr_cyc_log[wb], 2);
    check("t1_done_count", done_cnt - db, 1);
    check("t1_frame_len", bus.frame_len, 3);
    check("t1_err_count", err_cnt - eb, 0);
    check("t1_busy_hold", bus.busy, 1);
    ack_pulse();
    check("t1_busy_after_ack", bus.busy, 0);

    // Checksum error (sum 0x32), then a frame whose checksum wraps to 0x00.
    wb = wr_cnt; eb = err_cnt;
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_seq();
    idle(2);
    check("t2_wr_count", wr_cnt - wb, 2);
    check("t2_data1", wr_data_log[wb+1], 32'h20);
    check("t2_err_count", err_cnt - eb, 1);
    check("t2_err_code", bus.err_code, 1);
    check("t2_busy", bus.busy, 0);
    wb = wr_cnt; db = done_cnt;
    seq = '{8'hA5, 8'h01, 8'hFF, 8'h00};
    send_seq();
    idle(2);
    check("t2_wrap_done", done_cnt - db, 1);
    check("t2_wrap_len", bus.frame_len, 1);
    check("t2_wrap_data", wr_data_log[wb], 32'hFF);
    check("t2_wrap_addr", wr_addr_log[wb], 0);
    ack_pulse();

    // Length 0 and length MAX_LEN+1.
    wb = wr_cnt; eb = err_cnt;
    seq = '{8'hA5, 8'h00};
    send_seq();
    idle(2);
    check("t3_len0_err", err_cnt - eb, 1);
    check("t3_len0_code", bus.err_code, 2);
    seq = '{8'hA5, 8'h41};
    send_seq();
    idle(2);
    check("t3_len41_err", err_cnt - eb, 2);
    check("t3_len41_code", bus.err_code, 2);
    check("t3_wr_count", wr_cnt - wb, 0);
    check("t3_frame_len_kept", bus.frame_len, 1);

    // Hold: dropped bytes, saturation, ack on the same edge as a byte.
    db = done_cnt;
    seq = '{8'hA5, 8'h01, 8'h07, 8'h08};
    send_seq();
    idle(1);
    wb = wr_cnt; eb = err_cnt;
    seq = '{8'hA5, 8'h00, 8'h11, 8'h22};
    send_seq();
    idle(2);
    check("t4_done", done_cnt - db, 1);
    check("t4_drop4", bus.drop_cnt, 4);
    check("t4_no_writes", wr_cnt - wb, 0);
    check("t4_no_err", err_cnt - eb, 0);
    check("t4_busy_hold", bus.busy, 1);
    ack_pulse();
    check("t4_drop_cleared", bus.drop_cnt, 0);
    check("t4_busy_cleared", bus.busy, 0);
    seq = '{8'hA5, 8'h01, 8'h07, 8'h08};
    send_seq();
    for (int i = 0; i < 256; i++) send_byte(8'h00);
    idle(1);
    check("t4_drop_sat", bus.drop_cnt, 255);
    present(8'hA5);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    check("t4_ack_edge_consume", bus.rx_clear, 1);
    @(negedge clk);
    bus.rx_available = 1'b0;
    idle(1);
    check("t4_ack_edge_drop", bus.drop_cnt, 0);
    check("t4_ack_edge_busy", bus.busy, 0);
    db = done_cnt;
    seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
    send_seq();
    idle(2);
    check("t4_next_done", done_cnt - db, 1);
    check("t4_next_len", bus.frame_len, 2);
    ack_pulse();

    // Partial frame followed by silence.
    wb = wr_cnt; eb = err_cnt;
    seq = '{8'hA5, 8'h02, 8'h11};
    send_seq();
`ifdef UART_FRAME_TIMEOUT_EN
    found = 1'b0;
    ecyc  = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (bus.frame_err) begin
        found = 1'b1;
        ecyc  = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("t5_tmo_seen", found, 1);
    check("t5_tmo_cycles", ecyc - clr_cyc, 100);
    check("t5_tmo_code", bus.err_code, 3);
    idle(1);
    check("t5_busy", bus.busy, 0);
`else
    idle(300);
    check("t5_no_err", err_cnt - eb, 0);
    check("t5_busy", bus.busy, 1);
`endif
    check("t5_wr_count", wr_cnt - wb, 1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset after two payload bytes with a sync byte pending in the receiver.
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22};
    send_seq();
    rst_n = 1'b0;
    present(8'hA5);
    idle(2);
    check_out_zero("t6_rst");
    wb = wr_cnt; db = done_cnt; eb = err_cnt;
    rst_n = 1'b1;
    finish_byte();
    seq = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq();
    idle(2);
    check("t6_done", done_cnt - db, 1);
    check("t6_len", bus.frame_len, 3);
    check("t6_wr_count", wr_cnt - wb, 3);
    check("t6_data2", wr_data_log[wb+2], 32'h33);
    check("t6_err", err_cnt - eb, 0);
    ack_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
